// File: rtl/vx_fetch_pkg.sv
// Shared types and default configuration for the out-of-order fetch front end.
package vx_fetch_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_NUM_WARPS       = 4;
  localparam int unsigned DEF_NUM_THREADS     = 4;
  localparam int unsigned DEF_PC_WIDTH        = 32;
  localparam int unsigned DEF_INSTR_WIDTH     = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_RSP_BUF_DEPTH   = 2;
  localparam int unsigned DEF_WID_W           = clog2_min1(DEF_NUM_WARPS);
  localparam int unsigned DEF_TAG_W           = $clog2(DEF_MAX_OUTSTANDING);

  typedef struct packed {
    logic [DEF_WID_W-1:0]       wid;
    logic [DEF_NUM_THREADS-1:0] tmask;
    logic [DEF_PC_WIDTH-1:0]    pc;
    logic                       squash;
  } fetch_entry_t;

  typedef struct packed {
    logic [DEF_WID_W-1:0]       wid;
    logic [DEF_NUM_THREADS-1:0] tmask;
    logic [DEF_PC_WIDTH-1:0]    pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } fetch_rsp_t;

endpackage

// File: rtl/vx_fetch_if.sv
// Fetch front-end bundle: scheduler request, icache request/response, decode response, flush.
// Defining FETCH_PERF_EN adds the performance counter outputs.
interface vx_fetch_if #(
  parameter int unsigned NUM_WARPS       = vx_fetch_pkg::DEF_NUM_WARPS,
  parameter int unsigned NUM_THREADS     = vx_fetch_pkg::DEF_NUM_THREADS,
  parameter int unsigned PC_WIDTH        = vx_fetch_pkg::DEF_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH     = vx_fetch_pkg::DEF_INSTR_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = vx_fetch_pkg::DEF_MAX_OUTSTANDING
);
  import vx_fetch_pkg::*;

  localparam int unsigned WID_W = clog2_min1(NUM_WARPS);
  localparam int unsigned TAG_W = $clog2(MAX_OUTSTANDING);

  logic                   req_valid;
  logic                   req_ready;
  logic [WID_W-1:0]       req_wid;
  logic [NUM_THREADS-1:0] req_tmask;
  logic [PC_WIDTH-1:0]    req_pc;

  logic                   icache_req_valid;
  logic                   icache_req_ready;
  logic [PC_WIDTH-1:0]    icache_req_addr;
  logic [TAG_W-1:0]       icache_req_tag;

  logic                   icache_rsp_valid;
  logic                   icache_rsp_ready;
  logic [INSTR_WIDTH-1:0] icache_rsp_data;
  logic [TAG_W-1:0]       icache_rsp_tag;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WID_W-1:0]       rsp_wid;
  logic [NUM_THREADS-1:0] rsp_tmask;
  logic [PC_WIDTH-1:0]    rsp_pc;
  logic [INSTR_WIDTH-1:0] rsp_instr;

  logic                   flush_valid;
  logic [WID_W-1:0]       flush_wid;
  logic                   busy;

`ifdef FETCH_PERF_EN
  logic [63:0]            perf_fetches;
  logic [63:0]            perf_stall_cycles;
  logic [31:0]            perf_squashed;
`endif

  // Fetch unit side.
  modport slave (
    input  req_valid, req_wid, req_tmask, req_pc,
    output req_ready,
    output icache_req_valid, icache_req_addr, icache_req_tag,
    input  icache_req_ready,
    input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    output icache_rsp_ready,
    output rsp_valid, rsp_wid, rsp_tmask, rsp_pc, rsp_instr,
    input  rsp_ready,
    input  flush_valid, flush_wid,
    output busy
`ifdef FETCH_PERF_EN
    , output perf_fetches, perf_stall_cycles, perf_squashed
`endif
  );

  // Scheduler / icache / decode side.
  modport master (
    output req_valid, req_wid, req_tmask, req_pc,
    input  req_ready,
    input  icache_req_valid, icache_req_addr, icache_req_tag,
    output icache_req_ready,
    output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    input  icache_rsp_ready,
    input  rsp_valid, rsp_wid, rsp_tmask, rsp_pc, rsp_instr,
    output rsp_ready,
    output flush_valid, flush_wid,
    input  busy
`ifdef FETCH_PERF_EN
    , input perf_fetches, perf_stall_cycles, perf_squashed
`endif
  );

endinterface

// File: rtl/vx_fetch_rsp_fifo.sv
// Compacting response FIFO: the head always sits in entry 0 so the output comes straight
// from flops; a per-warp purge drops matching entries and closes the gaps.
module vx_fetch_rsp_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WID_W  = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WID_W-1:0]  i_push_wid,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_purge,
  input  logic [WID_W-1:0]  i_purge_wid,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_d;
  logic [WID_W-1:0]  r_wid    [DEPTH];
  logic [WID_W-1:0]  w_wid_d  [DEPTH];
  logic [DATA_W-1:0] r_data   [DEPTH];
  logic [DATA_W-1:0] w_data_d [DEPTH];

  // Survivors are packed towards entry 0 in order; the push lands after them.
  always_comb begin
    w_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wid_d[i]  = '0;
      w_data_d[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && !((i == 0) && i_pop) &&
          !(i_purge && (r_wid[i] == i_purge_wid))) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CNT_W'(j) == w_count_d) begin
            w_wid_d[j]  = r_wid[i];
            w_data_d[j] = r_data[i];
          end
        end
        w_count_d = w_count_d + 1'b1;
      end
    end
    if (i_push && (w_count_d < CNT_W'(DEPTH))) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CNT_W'(j) == w_count_d) begin
          w_wid_d[j]  = i_push_wid;
          w_data_d[j] = i_push_data;
        end
      end
      w_count_d = w_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wid[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_count <= w_count_d;
      r_wid   <= w_wid_d;
      r_data  <= w_data_d;
    end
  end

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_data = r_data[0];

endmodule

// File: rtl/vx_fetch_ooo.sv
// Multi-warp fetch front end: tags fetches, accepts out-of-order icache responses, squashes
// per warp on flush and queues results to decode. FETCH_PERF_EN adds perf counters.
module vx_fetch_ooo
  import vx_fetch_pkg::*;
#(
  parameter int unsigned NUM_WARPS       = DEF_NUM_WARPS,
  parameter int unsigned NUM_THREADS     = DEF_NUM_THREADS,
  parameter int unsigned PC_WIDTH        = DEF_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH     = DEF_INSTR_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned RSP_BUF_DEPTH   = DEF_RSP_BUF_DEPTH
) (
  input logic       clk,
  input logic       reset,
  vx_fetch_if.slave bus
);

  localparam int unsigned WID_W = clog2_min1(NUM_WARPS);
  localparam int unsigned TAG_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned RSP_W = WID_W + NUM_THREADS + PC_WIDTH + INSTR_WIDTH;

  typedef struct packed {
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_WIDTH-1:0]    pc;
    logic                   squash;
  } entry_t;

  typedef struct packed {
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } rsp_t;

  logic [MAX_OUTSTANDING-1:0] r_valid;
  logic [MAX_OUTSTANDING-1:0] w_valid_d;
  logic [MAX_OUTSTANDING-1:0] w_free;
  entry_t                     r_entry   [MAX_OUTSTANDING];
  entry_t                     w_entry_d [MAX_OUTSTANDING];
  entry_t                     w_rsp_entry;
  logic [TAG_W-1:0]           w_slot;
  logic                       w_any_free;
  logic                       w_req_fire;
  logic                       w_irsp_fire;
  logic                       w_tag_live;
  logic                       w_flush_hit;
  logic                       w_rsp_drop;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  rsp_t                       w_push_rsp;
  rsp_t                       w_head_rsp;

  // Free slots are taken from the registered valid bits, so a slot released this cycle
  // only becomes allocatable on the next one.
  assign w_free     = ~r_valid;
  assign w_any_free = |w_free;

  always_comb begin
    w_slot = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (w_free[i]) w_slot = TAG_W'(i);
    end
  end

  assign bus.icache_req_valid = bus.req_valid & w_any_free;
  assign bus.req_ready        = bus.icache_req_ready & w_any_free;
  assign bus.icache_req_addr  = bus.req_pc;
  assign bus.icache_req_tag   = w_slot;
  assign w_req_fire           = bus.req_valid & bus.req_ready;

  assign w_rsp_entry          = r_entry[bus.icache_rsp_tag];
  assign w_tag_live           = r_valid[bus.icache_rsp_tag];
  assign bus.icache_rsp_ready = ~w_fifo_full | w_rsp_entry.squash;
  assign w_irsp_fire          = bus.icache_rsp_valid & bus.icache_rsp_ready;
  assign w_flush_hit          = bus.flush_valid & (w_rsp_entry.wid == bus.flush_wid);
  assign w_rsp_drop           = w_rsp_entry.squash | w_flush_hit;
  assign w_push               = w_irsp_fire & w_tag_live & ~w_rsp_drop;

  // Flush marks before allocation so a same-cycle allocation always starts unsquashed.
  always_comb begin
    w_valid_d = r_valid;
    w_entry_d = r_entry;
    if (bus.flush_valid) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (r_valid[i] && (r_entry[i].wid == bus.flush_wid)) w_entry_d[i].squash = 1'b1;
      end
    end
    if (w_irsp_fire && w_tag_live) w_valid_d[bus.icache_rsp_tag] = 1'b0;
    if (w_req_fire) begin
      w_valid_d[w_slot] = 1'b1;
      w_entry_d[w_slot] = '{wid: bus.req_wid, tmask: bus.req_tmask, pc: bus.req_pc,
                            squash: 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_entry[i] <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_entry <= w_entry_d;
    end
  end

  assign w_push_rsp = '{wid: w_rsp_entry.wid, tmask: w_rsp_entry.tmask, pc: w_rsp_entry.pc,
                        instr: bus.icache_rsp_data};
  assign w_pop      = ~w_fifo_empty & bus.rsp_ready;

  vx_fetch_rsp_fifo #(
    .DATA_W (RSP_W),
    .WID_W  (WID_W),
    .DEPTH  (RSP_BUF_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_wid  (w_rsp_entry.wid),
    .i_push_data (w_push_rsp),
    .i_pop       (w_pop),
    .i_purge     (bus.flush_valid),
    .i_purge_wid (bus.flush_wid),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head_data (w_head_rsp)
  );

  assign bus.rsp_valid = ~w_fifo_empty;
  assign bus.rsp_wid   = w_head_rsp.wid;
  assign bus.rsp_tmask = w_head_rsp.tmask;
  assign bus.rsp_pc    = w_head_rsp.pc;
  assign bus.rsp_instr = w_head_rsp.instr;
  assign bus.busy      = (|r_valid) | ~w_fifo_empty;

`ifdef FETCH_PERF_EN
  logic [63:0] r_perf_fetches;
  logic [63:0] r_perf_stall;
  logic [31:0] r_perf_squashed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetches  <= '0;
      r_perf_stall    <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (w_pop && (r_perf_fetches != '1)) r_perf_fetches <= r_perf_fetches + 64'd1;
      if (bus.req_valid && !bus.req_ready && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
      if (w_irsp_fire && w_tag_live && w_rsp_drop && (r_perf_squashed != '1)) begin
        r_perf_squashed <= r_perf_squashed + 32'd1;
      end
    end
  end

  assign bus.perf_fetches      = r_perf_fetches;
  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_squashed     = r_perf_squashed;
`endif

  a_rsp_tag_live: assert property (@(posedge clk) disable iff (reset) w_irsp_fire |-> w_tag_live)
    else $error("icache response for idle tag %0d", bus.icache_rsp_tag);

endmodule

// File: tb/tb_vx_fetch_ooo.sv
// Scoreboard bench for vx_fetch_ooo: a tag-table model predicts icache tags and which
// responses reach decode; a negedge monitor compares decode output against the queue.
module tb_vx_fetch_ooo;
  import vx_fetch_pkg::*;

  localparam int Budget = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  vx_fetch_if bus ();

  vx_fetch_ooo u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit         m_valid  [4];
  bit         m_squash [4];
  logic [1:0] m_wid    [4];
  logic [3:0] m_tmask  [4];
  logic [31:0] m_pc    [4];
  fetch_rsp_t exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] wid, input logic [3:0] tm, input logic [31:0] pc);
    int slot;
    bit done;
    slot = lowest_free();
    done = 0;
    bus.req_valid = 1'b1;
    bus.req_wid   = wid;
    bus.req_tmask = tm;
    bus.req_pc    = pc;
    for (int c = 0; c < Budget && !done; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        check_eq("req_tag", 64'(bus.icache_req_tag), 64'(slot));
        check_eq("req_addr", 64'(bus.icache_req_addr), 64'(pc));
        done = 1;
      end
      tick();
    end
    check_eq("req_done", 64'(done), 64'd1);
    if (done && slot >= 0) begin
      m_valid[slot]  = 1'b1;
      m_squash[slot] = 1'b0;
      m_wid[slot]    = wid;
      m_tmask[slot]  = tm;
      m_pc[slot]     = pc;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic do_rsp(input int tag, input logic [31:0] data);
    bit done;
    bit drop;
    fetch_rsp_t e;
    done = 0;
    drop = 0;
    bus.icache_rsp_valid = 1'b1;
    bus.icache_rsp_tag   = 2'(tag);
    bus.icache_rsp_data  = data;
    for (int c = 0; c < Budget && !done; c++) begin
      @(negedge clk);
      if (bus.icache_rsp_ready) begin
        done = 1;
        drop = m_squash[tag] || (bus.flush_valid && (bus.flush_wid == m_wid[tag]));
      end
      tick();
    end
    check_eq("rsp_done", 64'(done), 64'd1);
    if (done) begin
      if (!drop) begin
        e.wid   = m_wid[tag];
        e.tmask = m_tmask[tag];
        e.pc    = m_pc[tag];
        e.instr = data;
        exp_q.push_back(e);
      end
      m_valid[tag] = 1'b0;
    end
    bus.icache_rsp_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [1:0] wid);
    bus.flush_valid = 1'b1;
    bus.flush_wid   = wid;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_wid[i] == wid) m_squash[i] = 1'b1;
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].wid == wid) exp_q.delete(i);
    tick();
    bus.flush_valid = 1'b0;
  endtask

  // Decode-side scoreboard: a transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    fetch_rsp_t e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_wid", 64'(bus.rsp_wid), 64'(e.wid));
        check_eq("rsp_tmask", 64'(bus.rsp_tmask), 64'(e.tmask));
        check_eq("rsp_pc", 64'(bus.rsp_pc), 64'(e.pc));
        check_eq("rsp_instr", 64'(bus.rsp_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FETCH_PERF_EN
    logic [63:0] f0;
    logic [63:0] s0;
`endif
    bus.req_valid        = 1'b0;
    bus.req_wid          = '0;
    bus.req_tmask        = '0;
    bus.req_pc           = '0;
    bus.icache_req_ready = 1'b1;
    bus.icache_rsp_valid = 1'b0;
    bus.icache_rsp_tag   = '0;
    bus.icache_rsp_data  = '0;
    bus.rsp_ready        = 1'b1;
    bus.flush_valid      = 1'b0;
    bus.flush_wid        = '0;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_rsp_pc", 64'(bus.rsp_pc), 64'd0);
    check_eq("rst_rsp_instr", 64'(bus.rsp_instr), 64'd0);
    reset = 1'b0;
    tick();

    // Single fetch with one-cycle response latency into decode.
    do_req(2'd1, 4'hf, 32'h80);
    do_rsp(0, 32'h13);
    @(negedge clk);
    check_eq("t1_latency", 64'(bus.rsp_valid), 64'd1);
    tick();
    @(negedge clk);
    check_eq("t1_idle", 64'(bus.busy), 64'd0);
    tick();

    // Fill all tags, stall, then answer out of order.
    for (int i = 0; i < 4; i++) do_req(2'(i), 4'(i + 1), 32'h100 + 32'(i * 4));
    bus.req_valid = 1'b1;
    @(negedge clk);
    check_eq("t2_req_ready_full", 64'(bus.req_ready), 64'd0);
    check_eq("t2_icache_valid_full", 64'(bus.icache_req_valid), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    do_rsp(3, 32'ha3);
    do_rsp(0, 32'ha0);
    do_rsp(2, 32'ha2);
    do_rsp(1, 32'ha1);
    repeat (3) tick();

    // Flush with two tags in flight; both responses dropped.
    do_req(2'd2, 4'h3, 32'h400);
    do_req(2'd2, 4'h3, 32'h404);
    do_flush(2'd2);
    do_rsp(0, 32'hdead);
    do_rsp(1, 32'hbeef);
    @(negedge clk);
    check_eq("t3_busy", 64'(bus.busy), 64'd0);
    check_eq("t3_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick();

    // Response arriving in the flush cycle of its warp is dropped.
    do_req(2'd3, 4'h1, 32'h500);
    bus.flush_valid = 1'b1;
    bus.flush_wid   = 2'd3;
    do_rsp(0, 32'h55);
    bus.flush_valid = 1'b0;
    @(negedge clk);
    check_eq("t3b_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("t3b_busy", 64'(bus.busy), 64'd0);
    tick();

    // Purge of queued FIFO entries by warp, survivor moves to head.
    bus.rsp_ready = 1'b0;
    do_req(2'd0, 4'h7, 32'h600);
    do_req(2'd2, 4'h7, 32'h604);
    do_rsp(1, 32'h61);
    do_rsp(0, 32'h60);
    do_flush(2'd2);
    @(negedge clk);
    check_eq("t3c_head_wid", 64'(bus.rsp_wid), 64'd0);
    check_eq("t3c_head_pc", 64'(bus.rsp_pc), 64'h600);
    tick();
    bus.rsp_ready = 1'b1;
    repeat (3) tick();

    // Backpressure: FIFO holds two, third response blocked until a pop.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(2'd1, 4'h5, 32'h300 + 32'(i * 4));
    do_rsp(0, 32'h30);
    do_rsp(1, 32'h31);
    bus.icache_rsp_tag = 2'd2;
    @(negedge clk);
    check_eq("t4_icache_rsp_ready", 64'(bus.icache_rsp_ready), 64'd0);
    check_eq("t4_head_pc", 64'(bus.rsp_pc), 64'h300);
    tick();
    @(negedge clk);
    check_eq("t4_head_stable", 64'(bus.rsp_pc), 64'h300);
    tick();
    bus.rsp_ready = 1'b1;
    do_rsp(2, 32'h32);
    repeat (3) tick();

    // Asynchronous reset mid-flight.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(2'd0, 4'h2, 32'h700 + 32'(i * 4));
    do_rsp(2, 32'h72);
    @(negedge clk);
    check_eq("t5_busy_before", 64'(bus.busy), 64'd1);
    tick();
    reset = 1'b1;
    #1;
    check_eq("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("t5_busy", 64'(bus.busy), 64'd0);
    check_eq("t5_rsp_pc", 64'(bus.rsp_pc), 64'd0);
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    do_req(2'd1, 4'h9, 32'h800);
    do_rsp(0, 32'h88);
    repeat (3) tick();

`ifdef FETCH_PERF_EN
    f0 = bus.perf_fetches;
    s0 = bus.perf_stall_cycles;
    for (int i = 0; i < 4; i++) do_req(2'(i), 4'hf, 32'h900 + 32'(i * 4));
    bus.req_valid = 1'b1;
    repeat (3) tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) do_rsp(i, 32'h90 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      do_req(2'd1, 4'h1, 32'ha00 + 32'(i * 4));
      do_rsp(0, 32'hb0 + 32'(i));
    end
    repeat (4) tick();
    check_eq("t6_perf_fetches", bus.perf_fetches - f0, 64'd10);
    check_eq("t6_perf_stall", bus.perf_stall_cycles - s0, 64'd3);
`endif

    check_eq("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
